// File: rtl/frac_me_pkg.sv
// Shared types and constants for the fractional-position SAD search.
// Candidate index = 5*row + col; rows UH,UQ,M,LQ,LH; cols h,q,f,q,h.
package frac_me_pkg;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      SEARCH = 2'd1,
      OUT    = 2'd2
   } state_e;

   localparam int unsigned GRID_ROWS = 5;
   localparam int unsigned GRID_COLS = 5;

   function automatic int unsigned sad_w(input int unsigned pix_w, input int unsigned lanes,
                                         input int unsigned blk_h);
      return pix_w + $clog2(lanes) + $clog2(blk_h);
   endfunction

   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned IDX_UH_H  = 0;
   localparam int unsigned IDX_UH_Q  = 1;
   localparam int unsigned IDX_UH_F  = 2;
   localparam int unsigned IDX_UH_Q2 = 3;
   localparam int unsigned IDX_UH_H2 = 4;
   localparam int unsigned IDX_UQ_H  = 5;
   localparam int unsigned IDX_UQ_Q  = 6;
   localparam int unsigned IDX_UQ_F  = 7;
   localparam int unsigned IDX_UQ_Q2 = 8;
   localparam int unsigned IDX_UQ_H2 = 9;
   localparam int unsigned IDX_M_H   = 10;
   localparam int unsigned IDX_M_Q   = 11;
   localparam int unsigned IDX_M_F   = 12;
   localparam int unsigned IDX_M_Q2  = 13;
   localparam int unsigned IDX_M_H2  = 14;
   localparam int unsigned IDX_LQ_H  = 15;
   localparam int unsigned IDX_LQ_Q  = 16;
   localparam int unsigned IDX_LQ_F  = 17;
   localparam int unsigned IDX_LQ_Q2 = 18;
   localparam int unsigned IDX_LQ_H2 = 19;
   localparam int unsigned IDX_LH_H  = 20;
   localparam int unsigned IDX_LH_Q  = 21;
   localparam int unsigned IDX_LH_F  = 22;
   localparam int unsigned IDX_LH_Q2 = 23;
   localparam int unsigned IDX_LH_H2 = 24;

endpackage

// File: rtl/frac_sad_search_if.sv
// Row-in / result-out handshake bundle between the ME controller and the SAD search.
interface frac_sad_search_if #(
   parameter int unsigned PIX_W    = 8,
   parameter int unsigned LANES    = 8,
   parameter int unsigned NUM_CAND = 25,
   parameter int unsigned SAD_W    = 14,
   parameter int unsigned IDX_W    = 5
);
   logic                            in_valid;
   logic                            in_ready;
   logic [LANES*PIX_W-1:0]          org_pix;
   logic [NUM_CAND*LANES*PIX_W-1:0] cand_pix;
   logic [NUM_CAND-1:0]             cand_mask;
   logic                            out_valid;
   logic                            out_ready;
   logic [IDX_W-1:0]                best_idx;
   logic [SAD_W-1:0]                best_sad;
   logic                            out_none;

   modport master (
      output in_valid, org_pix, cand_pix, cand_mask, out_ready,
      input  in_ready, out_valid, best_idx, best_sad, out_none
   );

   modport slave (
      input  in_valid, org_pix, cand_pix, cand_mask, out_ready,
      output in_ready, out_valid, best_idx, best_sad, out_none
   );
endinterface

// File: rtl/sad_row_tree.sv
// Combinational row SAD: per-lane absolute difference followed by a balanced adder tree.
module sad_row_tree #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned LANES = 8,
   parameter int unsigned ROW_W = PIX_W + $clog2(LANES)
) (
   input  logic [LANES*PIX_W-1:0] org_pix,
   input  logic [LANES*PIX_W-1:0] cand_pix,
   output logic [ROW_W-1:0]       row_sum
);
   localparam int unsigned NP = 1 << $clog2(LANES);

   logic [PIX_W-1:0] diff [LANES];
   logic [ROW_W-1:0] node [2*NP];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [PIX_W-1:0] a;
      logic [PIX_W-1:0] b;
      assign a       = org_pix[l*PIX_W +: PIX_W];
      assign b       = cand_pix[l*PIX_W +: PIX_W];
      assign diff[l] = (a > b) ? (a - b) : (b - a);
   end

   // Heap-ordered tree: leaves at NP..2*NP-1, node i sums children 2i and 2i+1.
   always_comb begin
      for (int unsigned i = 0; i < 2*NP; i++) begin
         node[i] = '0;
      end
      for (int unsigned i = 0; i < LANES; i++) begin
         node[NP+i] = ROW_W'(diff[i]);
      end
      for (int unsigned i = NP - 1; i >= 1; i--) begin
         node[i] = node[2*i] + node[2*i+1];
      end
   end

   assign row_sum = node[1];
endmodule

// File: rtl/frac_sad_search.sv
// Block SAD accumulation over BLK_H rows for NUM_CAND fractional candidates,
// followed by a one-candidate-per-cycle minimum search with valid/ready result.
module frac_sad_search
   import frac_me_pkg::*;
#(
   parameter int unsigned PIX_W    = 8,
   parameter int unsigned LANES    = 8,
   parameter int unsigned NUM_CAND = 25,
   parameter int unsigned BLK_H    = 8,
   parameter int unsigned SAD_W    = sad_w(PIX_W, LANES, BLK_H),
   parameter int unsigned IDX_W    = idx_w(NUM_CAND)
) (
   input logic               clk,
   input logic               rst,
   frac_sad_search_if.slave  bus
);
   localparam int unsigned ROW_W = PIX_W + $clog2(LANES);
   localparam int unsigned CNT_W = $clog2(BLK_H + 1);

   logic [ROW_W-1:0] row_sum [NUM_CAND];

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    row_cnt_q, row_cnt_d;
   logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
   logic                s1_valid_q, s1_valid_d;
   logic [ROW_W-1:0]    s1_q [NUM_CAND];
   logic [ROW_W-1:0]    s1_d [NUM_CAND];
   logic [NUM_CAND-1:0] mask_q, mask_d;
   logic [SAD_W-1:0]    acc_q [NUM_CAND];
   logic [SAD_W-1:0]    acc_d [NUM_CAND];
   logic [IDX_W-1:0]    k_q, k_d;
   logic [SAD_W-1:0]    best_sad_q, best_sad_d;
   logic [IDX_W-1:0]    best_idx_q, best_idx_d;
   logic                best_none_q, best_none_d;

   logic in_ready_int;
   logic accept;

   for (genvar k = 0; k < NUM_CAND; k++) begin : g_cand
      sad_row_tree #(
         .PIX_W (PIX_W),
         .LANES (LANES),
         .ROW_W (ROW_W)
      ) u_tree (
         .org_pix  (bus.org_pix),
         .cand_pix (bus.cand_pix[k*LANES*PIX_W +: LANES*PIX_W]),
         .row_sum  (row_sum[k])
      );
   end

   assign in_ready_int = (state_q == ACCUM) && (row_cnt_q < CNT_W'(BLK_H));

   always_comb begin
      state_d     = state_q;
      row_cnt_d   = row_cnt_q;
      acc_cnt_d   = acc_cnt_q;
      s1_valid_d  = 1'b0;
      s1_d        = s1_q;
      mask_d      = mask_q;
      acc_d       = acc_q;
      k_d         = k_q;
      best_sad_d  = best_sad_q;
      best_idx_d  = best_idx_q;
      best_none_d = best_none_q;
      accept      = bus.in_valid && in_ready_int;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_d       = row_sum;
         row_cnt_d  = row_cnt_q + CNT_W'(1);
         if (row_cnt_q == '0) begin
            mask_d = bus.cand_mask;
         end
      end

      case (state_q)
         ACCUM: begin
            // The first accumulated row overwrites, so no clear is needed between blocks.
            if (s1_valid_q) begin
               for (int unsigned k = 0; k < NUM_CAND; k++) begin
                  acc_d[k] = (acc_cnt_q == '0) ? SAD_W'(s1_q[k])
                                               : acc_q[k] + SAD_W'(s1_q[k]);
               end
               acc_cnt_d = acc_cnt_q + CNT_W'(1);
               if (acc_cnt_d == CNT_W'(BLK_H)) begin
                  state_d     = SEARCH;
                  k_d         = '0;
                  best_sad_d  = '1;
                  best_idx_d  = '0;
                  best_none_d = 1'b1;
               end
            end
         end
         SEARCH: begin
            if (mask_q[k_q] && (best_none_q || (acc_q[k_q] < best_sad_q))) begin
               best_sad_d  = acc_q[k_q];
               best_idx_d  = k_q;
               best_none_d = 1'b0;
            end
            if (k_q == IDX_W'(NUM_CAND - 1)) begin
               state_d = OUT;
            end else begin
               k_d = k_q + IDX_W'(1);
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               state_d   = ACCUM;
               row_cnt_d = '0;
               acc_cnt_d = '0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ACCUM;
         row_cnt_q   <= '0;
         acc_cnt_q   <= '0;
         s1_valid_q  <= 1'b0;
         mask_q      <= '0;
         k_q         <= '0;
         best_sad_q  <= '0;
         best_idx_q  <= '0;
         best_none_q <= 1'b0;
         for (int unsigned k = 0; k < NUM_CAND; k++) begin
            s1_q[k]  <= '0;
            acc_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         acc_cnt_q   <= acc_cnt_d;
         s1_valid_q  <= s1_valid_d;
         mask_q      <= mask_d;
         k_q         <= k_d;
         best_sad_q  <= best_sad_d;
         best_idx_q  <= best_idx_d;
         best_none_q <= best_none_d;
         s1_q        <= s1_d;
         acc_q       <= acc_d;
      end
   end

   assign bus.in_ready  = in_ready_int && !rst;
   assign bus.out_valid = (state_q == OUT) && !rst;
   assign bus.best_idx  = best_idx_q;
   assign bus.best_sad  = best_sad_q;
   assign bus.out_none  = best_none_q;
endmodule

// File: tb/tb_frac_sad_search.sv
// Bench for frac_sad_search: directed vector table, handshake/reset sequences,
// and random blocks checked against an arithmetic SAD/min reference.
module tb_frac_sad_search;
   import frac_me_pkg::*;

   localparam int unsigned PIX_W    = 8;
   localparam int unsigned LANES    = 8;
   localparam int unsigned NUM_CAND = 25;
   localparam int unsigned BLK_H    = 8;
   localparam int unsigned SAD_W    = sad_w(PIX_W, LANES, BLK_H);
   localparam int unsigned IDX_W    = idx_w(NUM_CAND);
   localparam int          LAT      = NUM_CAND + 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   frac_sad_search_if #(
      .PIX_W    (PIX_W),
      .LANES    (LANES),
      .NUM_CAND (NUM_CAND),
      .SAD_W    (SAD_W),
      .IDX_W    (IDX_W)
   ) bus ();

   frac_sad_search #(
      .PIX_W    (PIX_W),
      .LANES    (LANES),
      .NUM_CAND (NUM_CAND),
      .BLK_H    (BLK_H)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   int                  org_a  [BLK_H][LANES];
   int                  cand_a [BLK_H][NUM_CAND][LANES];
   logic [NUM_CAND-1:0] mask_a [BLK_H];
   int                  last_acc;

   typedef struct {
      int                  org;
      int                  base;
      int                  ka;
      int                  va;
      int                  kb;
      int                  vb;
      logic [NUM_CAND-1:0] mask;
      int                  e_idx;
      int                  e_sad;
      bit                  e_none;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // Later rows carry the inverted mask; only row 0's mask may matter.
   task automatic fill_const(input vec_t v);
      for (int r = 0; r < BLK_H; r++) begin
         mask_a[r] = (r == 0) ? v.mask : ~v.mask;
         for (int l = 0; l < LANES; l++) begin
            org_a[r][l] = v.org;
            for (int k = 0; k < NUM_CAND; k++) begin
               cand_a[r][k][l] = (k == v.ka) ? v.va : (k == v.kb) ? v.vb : v.base;
            end
         end
      end
   endtask

   task automatic fill_rand();
      int mode;
      int mm;
      mode = $urandom_range(0, 1);
      mm   = $urandom_range(0, 3);
      for (int r = 0; r < BLK_H; r++) begin
         for (int l = 0; l < LANES; l++) begin
            org_a[r][l] = $urandom_range(0, 255);
            for (int k = 0; k < NUM_CAND; k++) begin
               cand_a[r][k][l] = (mode == 0) ? int'($urandom_range(0, 255))
                                             : (org_a[r][l] + int'($urandom_range(0, 1))) % 256;
            end
         end
         mask_a[r] = NUM_CAND'($urandom);
      end
      case (mm)
         0: mask_a[0] = '1;
         1: mask_a[0] = '0;
         2: mask_a[0] = NUM_CAND'(1) << $urandom_range(0, NUM_CAND - 1);
         default: ;
      endcase
   endtask

   task automatic model(output int idx, output int sad, output bit none);
      int s;
      int d;
      none = 1'b1;
      idx  = 0;
      sad  = (1 << SAD_W) - 1;
      for (int k = 0; k < NUM_CAND; k++) begin
         if (mask_a[0][k]) begin
            s = 0;
            for (int r = 0; r < BLK_H; r++) begin
               for (int l = 0; l < LANES; l++) begin
                  d = org_a[r][l] - cand_a[r][k][l];
                  s += (d < 0) ? -d : d;
               end
            end
            if (none || s < sad) begin
               none = 1'b0;
               idx  = k;
               sad  = s;
            end
         end
      end
   endtask

   task automatic load_row(input int r);
      bus.cand_mask = mask_a[r];
      for (int l = 0; l < LANES; l++) begin
         bus.org_pix[l*PIX_W +: PIX_W] = PIX_W'(org_a[r][l]);
         for (int k = 0; k < NUM_CAND; k++) begin
            bus.cand_pix[(k*LANES+l)*PIX_W +: PIX_W] = PIX_W'(cand_a[r][k][l]);
         end
      end
   endtask

   task automatic drive_rows(input int nrows, input bit gap);
      int  r = 0;
      int  budget = 0;
      bit  phase = 1'b0;
      while (r < nrows && budget < 200) begin
         @(negedge clk);
         budget++;
         if (gap && phase) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            load_row(r);
         end
         phase = ~phase;
         if (bus.in_valid && bus.in_ready) begin
            r++;
            last_acc = cyc;
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (r < nrows) chk("rows_accepted", r, nrows);
   endtask

   task automatic run_and_get(input bit gap, input bit rdy_hi, output int lat);
      int n = 0;
      bus.out_ready = rdy_hi;
      drive_rows(BLK_H, gap);
      while (!bus.out_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
      lat = cyc - last_acc;
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("out_valid_drop", bus.out_valid, 0);
      bus.out_ready = 1'b0;
   endtask

   task automatic check_result(input string tag, input int e_idx, input int e_sad, input bit e_none);
      chk({tag, "_idx"},  bus.best_idx, e_idx);
      chk({tag, "_sad"},  bus.best_sad, e_sad);
      chk({tag, "_none"}, bus.out_none, e_none);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int m_idx;
      int m_sad;
      bit m_none;

      vecs[0] = '{10,  0, 7, 10, -1,  0, {NUM_CAND{1'b1}},  7,     0, 1'b0};
      vecs[1] = '{10,  0, 7, 10, -1,  0, NUM_CAND'(1),      0,   640, 1'b0};
      vecs[2] = '{10, 11, 3, 10,  9, 10, {NUM_CAND{1'b1}},  3,     0, 1'b0};
      vecs[3] = '{10, 10, 12, 12, -1, 0, NUM_CAND'(1) << 12, 12,  128, 1'b0};
      vecs[4] = '{10,  0, -1, 0, -1,  0, '0,                0, 16383, 1'b1};
      vecs[5] = '{255, 0, -1, 0, -1,  0, {NUM_CAND{1'b1}},  0, 16320, 1'b0};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.org_pix   = '0;
      bus.cand_pix  = '0;
      bus.cand_mask = '0;
      #1;
      chk("rst_in_ready",  bus.in_ready,  0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_best_idx",  bus.best_idx,  0);
      chk("rst_best_sad",  bus.best_sad,  0);
      chk("rst_out_none",  bus.out_none,  0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);

      for (int v = 0; v < 6; v++) begin
         fill_const(vecs[v]);
         run_and_get(1'b0, 1'b0, lat);
         check_result($sformatf("vec%0d", v), vecs[v].e_idx, vecs[v].e_sad, vecs[v].e_none);
         chk($sformatf("vec%0d_latency", v), lat, LAT);
         consume();
      end

      // Toggled in_valid must give the same result as the unstalled isolation block.
      fill_const(vecs[0]);
      run_and_get(1'b1, 1'b0, lat);
      check_result("gap", 7, 0, 1'b0);
      chk("gap_latency", lat, LAT);
      consume();

      // Result must hold steady while out_ready is low.
      fill_rand();
      model(m_idx, m_sad, m_none);
      run_and_get(1'b0, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_out_valid", bus.out_valid, 1);
         chk("stall_in_ready",  bus.in_ready,  0);
         check_result("stall", m_idx, m_sad, m_none);
      end
      consume();

      // Reset after 4 rows discards them; next 8 rows form a fresh block.
      fill_rand();
      drive_rows(4, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready",  bus.in_ready,  0);
      @(negedge clk);
      rst = 1'b0;
      fill_rand();
      model(m_idx, m_sad, m_none);
      run_and_get(1'b0, 1'b0, lat);
      check_result("after_rst", m_idx, m_sad, m_none);
      chk("after_rst_latency", lat, LAT);
      rst = 1'b1;
      #1;
      chk("outrst_out_valid", bus.out_valid, 0);
      chk("outrst_best_sad",  bus.best_sad,  0);
      @(negedge clk);
      rst = 1'b0;

      for (int b = 0; b < 14; b++) begin
         bit gap;
         bit rdy;
         gap = 1'($urandom_range(0, 1));
         rdy = 1'($urandom_range(0, 1));
         fill_rand();
         model(m_idx, m_sad, m_none);
         run_and_get(gap, rdy, lat);
         check_result($sformatf("rand%0d", b), m_idx, m_sad, m_none);
         chk($sformatf("rand%0d_latency", b), lat, LAT);
         consume();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/frac_sad_search.md
Name: frac_sad_search

Overview:
- Sequential successor to the combinational per-line fractional abs-diff stage. Accepts one block row per handshake: the original pixels plus NUM_CAND interpolated candidate rows (the 5x5 UH/UQ/M/LQ/LH × h/q/f/q/h grid by default).
- Computes per-candidate row SAD and accumulates it over BLK_H rows.
- Runs a sequential minimum search over the enabled candidates and presents the best index and SAD on a valid/ready output to the motion-estimation controller.

Parameters:
- PIX_W, 8, bits per pixel.
- LANES, 8, pixels per row.
- NUM_CAND, 25, candidate positions per row. Index = 5*row + col; row order UH,UQ,M,LQ,LH; col order h,q,f,q,h. Index 12 = M_f (integer position).
- BLK_H, 8, rows per block.
- SAD_W, PIX_W+clog2(LANES)+clog2(BLK_H) = 14, accumulator width; guaranteed overflow-free.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  row present.
- in_ready  out  1  row accepted when in_valid&in_ready.
- org_pix  in  LANES*PIX_W  original row; lane 0 in LSBs.
- cand_pix  in  NUM_CAND*LANES*PIX_W  candidate rows; candidate k at [k*LANES*PIX_W +: LANES*PIX_W].
- cand_mask  in  NUM_CAND  candidate enables; sampled on the first row of each block only.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed on out_valid&out_ready.
- best_idx  out  5  winning candidate index (clog2(NUM_CAND) bits).
- best_sad  out  SAD_W  winning SAD.
- out_none  out  1  no candidate was enabled.

Behaviour:
- Reset (async, active-high): state=ACCUM, row_cnt=0, acc_cnt=0, s1_valid=0, all accumulators 0. Outputs are all 0 while rst is high: in_ready, out_valid, best_idx, best_sad, out_none.
- State ACCUM:
  - in_ready=1 iff row_cnt<BLK_H.
  - On accept: per candidate, row_sum = Σ|org−cand| over LANES, unsigned, PIX_W+clog2(LANES) bits. row_sum is registered into s1 with s1_valid=1; row_cnt++.
  - If row_cnt==0 at accept, cand_mask is latched into mask_q.
  - Cycle after s1_valid: acc[k] = (acc_cnt==0 ? row_sum[k] : acc[k]+row_sum[k]); acc_cnt++.
  - When acc_cnt reaches BLK_H, next state is SEARCH.
  - Gaps in in_valid are allowed; no data is lost or duplicated.
- State SEARCH:
  - One candidate per cycle, k=0..NUM_CAND−1, exactly NUM_CAND cycles.
  - best initialised to sad=all-ones, idx=0, none=1.
  - Candidate k replaces best iff mask_q[k] && (none || acc[k] < best_sad), i.e. strict less-than. Ties therefore go to the lowest index.
  - After k=NUM_CAND−1, next state is OUT.
- State OUT:
  - out_valid=1; best_idx, best_sad, out_none are held stable until out_ready.
  - On handshake: row_cnt=0, acc_cnt=0, state=ACCUM.
  - in_ready=0 throughout SEARCH and OUT.
- Latency: last row accepted in cycle T → acc updated end of T+1 → SEARCH occupies T+2..T+1+NUM_CAND → out_valid from T+2+NUM_CAND. With zero stall, consecutive blocks are separated by BLK_H+NUM_CAND+2 cycles.
- Mask all zero: out_none=1, best_idx=0, best_sad=2^SAD_W−1.
- Reset mid-block discards partial accumulation; the next accepted row starts a fresh block.
- out_ready held high before out_valid has no effect.

Decomposition:
- Package frac_me_pkg:
  - state enum {ACCUM, SEARCH, OUT};
  - clog2-based SAD_W and IDX_W helper functions;
  - candidate index constants (IDX_UH_H=0 … IDX_M_F=12 … IDX_LH_H2=24);
  - grid dimensions 5×5.
- Sub-module sad_row_tree: abs-diff of LANES pixel pairs plus balanced adder tree, combinational, one instance per candidate. Reuses the existing per-pixel abs-diff cell.

Test Plan:
- Block isolation: org=10 all pixels; cand 7=10, all others=0; mask=all ones; 8 rows → best_idx=7, best_sad=0, out_none=0; acc of others=640; out_valid exactly 27 cycles after last accept with no stalls.
- Tie-break: cand 3 and cand 9 both equal org, others differ by 1 → best_idx=3, best_sad=0.
- Mask mode: mask=only bit 12, cand 12 differs by 2 per pixel, others equal org → best_idx=12, best_sad=128. Changing cand_mask after row 0 has no effect.
- Empty mask: mask=0 → out_none=1, best_idx=0, best_sad=16383.
- Width limit: org=255, all cands=0, 8 rows → every acc=16320, best_idx=0, best_sad=16320, no wrap.
- Handshake and reset:
  - in_valid toggled every other cycle → result identical to the unstalled run.
  - out_ready low 5 cycles → outputs stable, in_ready=0.
  - rst pulsed after 4 rows → out_valid=0 immediately; the next 8 rows give the result of those 8 rows only.
